// File: rtl/led_seq_pkg.sv
// led_seq_pkg: opcode constants, decode classes and sequencer states for the LED stack processor
package led_seq_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_WAIT       = 8'h01;
    localparam logic [7:0] OP_OFF        = 8'h02;
    localparam logic [7:0] OP_ON         = 8'h03;
    localparam logic [7:0] OP_TOGGLE     = 8'h04;
    localparam logic [7:0] OP_HALT       = 8'h05;
    localparam logic [7:0] OP_WAITN_MASK = 8'hC0;
    localparam logic [7:0] OP_WAITN_VAL  = 8'h40;
    localparam logic [7:0] OP_JUMP_MASK  = 8'h80;

    typedef enum logic [1:0] {RUN, WAIT, HALT} seq_state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_OFF,
        CL_ON,
        CL_TOGGLE,
        CL_HALT,
        CL_WAITN,
        CL_JUMP
    } instr_class_t;

endpackage

// File: rtl/led_seq_decode.sv
// led_seq_decode: combinational instruction byte decoder, shared with the disassembler/monitor
module led_seq_decode
    import led_seq_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic [7:0]        instr,
    output instr_class_t      cls,
    output logic [5:0]        wait_len,
    output logic [ADDR_W-1:0] jump_tgt
);

    assign wait_len = instr[5:0];
    assign jump_tgt = instr[ADDR_W-1:0];

    // JUMP owns the whole top half of the opcode space; undefined bytes fall through to NOP
    always_comb begin
        cls = (instr & OP_JUMP_MASK) != 8'h00               ? CL_JUMP   :
              (instr & OP_WAITN_MASK) == OP_WAITN_VAL       ? CL_WAITN  :
              (instr == OP_NOP || instr == OP_WAIT)         ? CL_NOP    :
              instr == OP_OFF                               ? CL_OFF    :
              instr == OP_ON                                ? CL_ON     :
              instr == OP_TOGGLE                            ? CL_TOGGLE :
              instr == OP_HALT                              ? CL_HALT   : CL_NOP;
    end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: tick-gated fetch/execute stage stepping a PC through the packed program and driving the LED
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_INSTR = 4,
    parameter int ADDR_W    = $clog2(NUM_INSTR)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   TICK,
    input  logic [8*NUM_INSTR-1:0] PROGRAM,
    output logic                   LED,
    output logic [ADDR_W-1:0]      PC,
    output logic                   BUSY,
    output logic                   HALTED,
    output logic                   RETIRE
);

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              led_q, led_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              retire_q, retire_d;
    logic [7:0]        instr;
    instr_class_t      cls;
    logic [5:0]        wait_len;
    logic [ADDR_W-1:0] jump_tgt;

    assign instr = PROGRAM[{pc_q, 3'b000} +: 8];

    led_seq_decode #(.ADDR_W(ADDR_W)) u_decode (
        .instr    (instr),
        .cls      (cls),
        .wait_len (wait_len),
        .jump_tgt (jump_tgt)
    );

    // Next state: nothing moves without TICK; PC wraps naturally since NUM_INSTR is a power of two
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        led_d    = led_q;
        cnt_d    = cnt_q;
        retire_d = 1'b0;
        if (TICK) begin
            case (state_q)
                RUN: begin
                    pc_d     = pc_q + PC_ONE;
                    retire_d = 1'b1;
                    case (cls)
                        CL_OFF:    led_d = 1'b0;
                        CL_ON:     led_d = 1'b1;
                        CL_TOGGLE: led_d = ~led_q;
                        CL_HALT: begin
                            state_d = HALT;
                            pc_d    = pc_q;
                        end
                        CL_WAITN: begin
                            if (wait_len > 6'd1) begin
                                state_d  = WAIT;
                                cnt_d    = wait_len - 6'd1;
                                retire_d = 1'b0;
                            end
                        end
                        CL_JUMP:   pc_d = jump_tgt;
                        default:   ;
                    endcase
                end
                WAIT: begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d  = RUN;
                        retire_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; reset abandons any wait and restarts at instruction 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= RUN;
            pc_q     <= '0;
            led_q    <= 1'b0;
            cnt_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
        end
    end

    assign LED    = led_q;
    assign PC     = pc_q;
    assign BUSY   = state_q == WAIT;
    assign HALTED = state_q == HALT;
    assign RETIRE = retire_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: table-driven directed checks of led_sequencer plus an asynchronous mid-wait reset sequence
module tb_led_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        TICK = 1'b0;
    logic [31:0] PROGRAM = '0;
    logic        LED;
    logic [1:0]  PC;
    logic        BUSY;
    logic        HALTED;
    logic        RETIRE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [31:0] prog;
        logic        tick;
        logic        led;
        logic [1:0]  pc;
        logic        busy;
        logic        halted;
        logic        retire;
    } vec_t;

    vec_t vecs[$];

    led_sequencer #(.NUM_INSTR(4)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .TICK    (TICK),
        .PROGRAM (PROGRAM),
        .LED     (LED),
        .PC      (PC),
        .BUSY    (BUSY),
        .HALTED  (HALTED),
        .RETIRE  (RETIRE)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic rst, input logic [31:0] prog, input logic tick, input logic led,
                       input logic [1:0] pc, input logic busy, input logic halted, input logic retire);
        vec_t v;
        v.rst = rst; v.prog = prog; v.tick = tick; v.led = led;
        v.pc = pc; v.busy = busy; v.halted = halted; v.retire = retire;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic led, input logic [1:0] pc, input logic busy,
                           input logic halted, input logic retire);
        chk("LED", idx, {7'd0, LED}, {7'd0, led});
        chk("PC", idx, {6'd0, PC}, {6'd0, pc});
        chk("BUSY", idx, {7'd0, BUSY}, {7'd0, busy});
        chk("HALTED", idx, {7'd0, HALTED}, {7'd0, halted});
        chk("RETIRE", idx, {7'd0, RETIRE}, {7'd0, retire});
    endtask

    task automatic step(input logic tick);
        @(negedge CLK);
        TICK = tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // ON, WAIT, OFF, WAIT loop (instr 0..3 = 03,01,02,01)
        add(1, 32'h01020103, 0, 0, 0, 0, 0, 0);
        add(0, 32'h01020103, 1, 1, 1, 0, 0, 1);
        add(0, 32'h01020103, 1, 1, 2, 0, 0, 1);
        add(0, 32'h01020103, 1, 0, 3, 0, 0, 1);
        add(0, 32'h01020103, 1, 0, 0, 0, 0, 1);
        add(0, 32'h01020103, 1, 1, 1, 0, 0, 1);
        add(0, 32'h01020103, 1, 1, 2, 0, 0, 1);
        add(0, 32'h01020103, 1, 0, 3, 0, 0, 1);
        add(0, 32'h01020103, 1, 0, 0, 0, 0, 1);
        add(0, 32'h01020103, 0, 0, 0, 0, 0, 0);
        // WAITN 3 then ON, with an idle cycle inside the wait
        add(1, 32'h00000343, 0, 0, 0, 0, 0, 0);
        add(0, 32'h00000343, 1, 0, 1, 1, 0, 0);
        add(0, 32'h00000343, 0, 0, 1, 1, 0, 0);
        add(0, 32'h00000343, 1, 0, 1, 1, 0, 0);
        add(0, 32'h00000343, 1, 0, 1, 0, 0, 1);
        add(0, 32'h00000343, 1, 1, 2, 0, 0, 1);
        // three toggles then HALT, which absorbs further ticks
        add(1, 32'h05040404, 0, 0, 0, 0, 0, 0);
        add(0, 32'h05040404, 1, 1, 1, 0, 0, 1);
        add(0, 32'h05040404, 1, 0, 2, 0, 0, 1);
        add(0, 32'h05040404, 1, 1, 3, 0, 0, 1);
        add(0, 32'h05040404, 1, 1, 3, 0, 1, 1);
        repeat (10) add(0, 32'h05040404, 1, 1, 3, 0, 1, 0);
        // TOGGLE + JUMP 0 tight loop, back-to-back ticks
        add(1, 32'h00008004, 0, 0, 0, 0, 0, 0);
        add(0, 32'h00008004, 1, 1, 1, 0, 0, 1);
        add(0, 32'h00008004, 1, 1, 0, 0, 0, 1);
        add(0, 32'h00008004, 1, 0, 1, 0, 0, 1);
        add(0, 32'h00008004, 1, 0, 0, 0, 0, 1);
        add(0, 32'h00008004, 1, 1, 1, 0, 0, 1);
        add(0, 32'h00008004, 1, 1, 0, 0, 0, 1);
        // undefined 0x3F, WAITN 0, ON, JUMP 0x85 (high target bits ignored -> 1)
        add(1, 32'h8503403F, 0, 0, 0, 0, 0, 0);
        add(0, 32'h8503403F, 1, 0, 1, 0, 0, 1);
        add(0, 32'h8503403F, 1, 0, 2, 0, 0, 1);
        add(0, 32'h8503403F, 1, 1, 3, 0, 0, 1);
        add(0, 32'h8503403F, 1, 1, 1, 0, 0, 1);
        add(0, 32'h8503403F, 1, 1, 2, 0, 0, 1);
        add(0, 32'h8503403F, 1, 1, 3, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            if (vecs[i].rst) begin
                TICK = 1'b0;
                PROGRAM = vecs[i].prog;
                RST_N = 1'b0;
                #1 RST_N = 1'b1;
            end
            TICK = vecs[i].tick;
            @(posedge CLK);
            #1;
            chk_all(i, vecs[i].led, vecs[i].pc, vecs[i].busy, vecs[i].halted, vecs[i].retire);
        end

        // asynchronous reset in the middle of WAITN 5 (instr 0 = TOGGLE, instr 1 = WAITN 5)
        @(negedge CLK);
        TICK = 1'b0;
        PROGRAM = 32'h00004504;
        RST_N = 1'b0;
        #1 RST_N = 1'b1;
        step(1);
        chk_all(100, 1, 1, 0, 0, 1);
        step(1);
        chk_all(101, 1, 2, 1, 0, 0);
        step(1);
        chk_all(102, 1, 2, 1, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        chk_all(103, 0, 0, 0, 0, 0);
        step(1);
        chk_all(104, 0, 0, 0, 0, 0);
        @(negedge CLK);
        TICK = 1'b0;
        RST_N = 1'b1;
        step(1);
        chk_all(105, 1, 1, 0, 0, 1);
        step(0);
        chk_all(106, 1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Instruction fetch/execute stage for the LED stack processor. Consumes the packed program word and the slow instruction-clock tick produced by the top-level clock divider, steps a program counter through the program, and drives the LED from the decoded instructions. All state advances in the fast `CLK` domain, gated by a one-cycle tick strobe. It does not use the divided clock as a clock.

## Interface
Parameters:
- `NUM_INSTR`, default 4: program length in instructions. Must be a power of two, 2..64.
- `ADDR_W`, default `$clog2(NUM_INSTR)`: program counter width. Derived; not overridden.

Ports:
- `CLK`, in, 1: system clock, 16 MHz.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `TICK`, in, 1: instruction-step strobe, synchronous to `CLK`. Each cycle it is high counts as one tick.
- `PROGRAM`, in, 8*NUM_INSTR: instruction `i` at `PROGRAM[8*i +: 8]`. Must be static while out of reset.
- `LED`, out, 1: LED drive.
- `PC`, out, ADDR_W: index of the next instruction to fetch.
- `BUSY`, out, 1: high while a multi-tick wait is in progress.
- `HALTED`, out, 1: high once HALT has executed.
- `RETIRE`, out, 1: one-cycle pulse when an instruction completes.

## Operation
Opcode encoding (8-bit):
- `0x00` NOP.
- `0x01` WAIT: one tick; identical in effect to NOP.
- `0x02` OFF: LED <= 0.
- `0x03` ON: LED <= 1.
- `0x04` TOGGLE: LED <= ~LED.
- `0x05` HALT.
- `0x40 | n` WAITN, `n` = bits [5:0]: occupies `n` ticks in total; `n` = 0 is treated as 1.
- `0x80 | a` JUMP: next PC = `a[ADDR_W-1:0]`; higher bits of `a` are ignored.
- Any other value: NOP.

FSM states: RUN, WAIT, HALT.
- RUN, on TICK: decode `PROGRAM` at `PC` and apply its effect.
  - Next PC is `PC+1`, wrapping `NUM_INSTR-1` to 0, except for JUMP.
  - WAITN with `n` >= 2: load `wait_cnt` = n-1, go to WAIT, and advance PC immediately.
  - HALT: go to HALT; PC is not advanced.
  - Every other opcode asserts RETIRE.
- WAIT, on TICK: decrement `wait_cnt`. When it reaches 0, assert RETIRE and return to RUN.
  - `BUSY` is high throughout WAIT.
  - Reading `PROGRAM` has no effect in this state.
- HALT: absorbing. Ignores TICK and holds LED and PC. Only `RST_N` exits.
  - RETIRE pulses once, on the tick that executes HALT.
- No TICK: no state, PC, LED or counter change in any state.
- `wait_cnt` is 6 bits; there is no underflow path.

## Timing
- Reset values, asynchronous on `RST_N` low:
  - LED = 0, PC = 0, BUSY = 0, HALTED = 0, RETIRE = 0.
  - State = RUN, `wait_cnt` = 0.
- Latency: the `CLK` edge that samples TICK high registers every effect (LED, PC, BUSY, HALTED, RETIRE). Effects are visible one cycle after TICK. There is no combinational path from TICK to any output.
- Back-to-back ticks (TICK high on consecutive cycles): one instruction or wait step per cycle. Throughput is 1 tick per cycle.
- RETIRE is high for exactly one cycle per retired instruction. A WAITN n raises RETIRE only on its final tick.
- Reset mid-WAIT: the wait is abandoned and execution restarts at PC 0 in RUN.
- `RST_N` deassertion is synchronised externally. The first tick after reset executes instruction 0.
- JUMP to its own index is legal and forms a tight loop, retiring on each tick.

## Structure
- Shared package `led_seq_pkg`:
  - opcode constants `OP_NOP`, `OP_WAIT`, `OP_OFF`, `OP_ON`, `OP_TOGGLE`, `OP_HALT`;
  - masks `OP_WAITN_MASK` (0xC0 → 0x40) and `OP_JUMP_MASK` (0x80);
  - state enum `seq_state_t` {RUN, WAIT, HALT}.
- Sub-module `led_seq_decode`: combinational. Byte in → {class, wait length, jump target} out. Shared with the future disassembler/monitor.
- The top level keeps its divider. `TICK` = rising edge of divider bit 24, detected in `CLK`.

## Test plan
- Program `{0x01,0x02,0x01,0x03}` (index 3..0), 8 ticks → LED sequence after each tick: 1,1,0,0,1,1,0,0; PC wraps 3→0; 8 RETIRE pulses.
- Instruction 0 = `0x43` (WAITN 3), instruction 1 = `0x03` → BUSY high after tick 1 until after tick 3; LED rises after tick 4; RETIRE on ticks 3 and 4 only.
- Program `{0x05,0x04,0x04,0x04}` → LED toggles 1,0,1, then HALTED=1 after tick 4; 10 further ticks change nothing; PC stays 3.
- Instruction 0 = `0x04`, instruction 1 = `0x80` (JUMP 0), 6 back-to-back ticks → LED 1,1,0,0,1,1; PC alternates 1,0.
- `RST_N` pulsed low mid-WAITN 5 after 2 ticks → LED=0, PC=0, BUSY=0 immediately (asynchronous); the next tick executes instruction 0.
- Undefined byte `0x3F` and WAITN 0 (`0x40`) → each retires in one tick with LED unchanged.
